// File: rtl/piezo_pkg.sv
// Shared encodings and default timing for the piezo buzzer arbiter.
package piezo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EVT  = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_T1   = 2'b01;
   localparam logic [1:0] SRC_T2   = 2'b10;
   localparam logic [1:0] SRC_MISS = 2'b11;

   localparam int unsigned DEF_DUR_HIT  = 100;
   localparam int unsigned DEF_DUR_MISS = 60;
   localparam int unsigned DEF_GAP_MS   = 5;

endpackage

// File: rtl/piezo_tick_timer.sv
// 16-bit down-counter in 1 ms ticks; load beats tick, done flags the 1->0 tick.
module piezo_tick_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        tick,
   output logic        done
);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 16'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (tick && cnt != 16'd0) begin
         cnt <= cnt - 16'd1;
      end
   end

   // Independent of load so the parent can reload from done without a loop.
   assign done = tick && (cnt == 16'd1);

endmodule

// File: rtl/piezo_arbiter.sv
// Fixed-priority buzzer arbiter (T1 > T2 > MISS) with timed sounds and silent gaps.
// Optional background melody in IDLE when PIEZO_ARBITER_BGM_EN is defined.
module piezo_arbiter
   import piezo_pkg::*;
#(
   parameter int unsigned DUR_HIT  = DEF_DUR_HIT,
   parameter int unsigned DUR_MISS = DEF_DUR_MISS,
   parameter int unsigned GAP_MS   = DEF_GAP_MS,
   parameter int unsigned PITCH_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_tick,
   input  logic               i_req_t1,
   input  logic [PITCH_W-1:0] i_pitch_t1,
   input  logic               i_req_t2,
   input  logic [PITCH_W-1:0] i_pitch_t2,
   input  logic               i_req_miss,
   input  logic [PITCH_W-1:0] i_pitch_miss,
   input  logic               i_bgm_en,
   input  logic [PITCH_W-1:0] i_bgm_pitch,
   output logic               o_play_en,
   output logic [PITCH_W-1:0] o_cnt_limit,
   output logic [1:0]         o_src,
   output logic               o_drop
);

   localparam logic [15:0] DUR_HIT_L  = 16'(DUR_HIT);
   localparam logic [15:0] DUR_MISS_L = 16'(DUR_MISS);
   localparam logic [15:0] GAP_L      = 16'(GAP_MS);

   state_t             state, state_n;
   logic               pend_t1, pend_t2, pend_miss;
   logic               pend_t1_n, pend_t2_n, pend_miss_n;
   logic [PITCH_W-1:0] pit_t1, pit_t2, pit_miss;
   logic [PITCH_W-1:0] eff_t1, eff_t2, eff_miss;
   logic               v_t1, v_t2, v_miss, zero_req;
   logic               grant;
   logic [1:0]         grant_src, pick;
   logic [PITCH_W-1:0] grant_pitch;
   logic               tmr_load, tmr_done;
   logic [15:0]        tmr_val;
   logic               play_n, drop_n;
   logic [PITCH_W-1:0] limit_n;
   logic [1:0]         src_n;

   // Zero-pitch requests are discarded rather than latched.
   assign v_t1     = i_req_t1   && (i_pitch_t1   != '0);
   assign v_t2     = i_req_t2   && (i_pitch_t2   != '0);
   assign v_miss   = i_req_miss && (i_pitch_miss != '0);
   assign zero_req = (i_req_t1 && !v_t1) || (i_req_t2 && !v_t2) || (i_req_miss && !v_miss);

   assign eff_t1   = v_t1   ? i_pitch_t1   : pit_t1;
   assign eff_t2   = v_t2   ? i_pitch_t2   : pit_t2;
   assign eff_miss = v_miss ? i_pitch_miss : pit_miss;

`ifndef PIEZO_ARBITER_BGM_EN
   logic bgm_unused;
   assign bgm_unused = ^{i_bgm_en, i_bgm_pitch};
`endif

   piezo_tick_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (i_tick),
      .done     (tmr_done)
   );

   always_comb begin
      pend_t1_n   = pend_t1   | v_t1;
      pend_t2_n   = pend_t2   | v_t2;
      pend_miss_n = pend_miss | v_miss;
      drop_n      = zero_req;
      state_n     = state;
      grant       = 1'b0;
      grant_src   = SRC_NONE;
      grant_pitch = o_cnt_limit;
      tmr_load    = 1'b0;
      tmr_val     = 16'd0;
      pick        = pend_t1_n ? SRC_T1 : pend_t2_n ? SRC_T2 :
                    pend_miss_n ? SRC_MISS : SRC_NONE;

      case (state)
         ST_IDLE: begin
            if (pick != SRC_NONE) begin
               grant     = 1'b1;
               grant_src = pick;
            end
         end
         ST_EVT: begin
            // Only fresh hit pulses preempt; a same-cycle tick loses to the reload.
            if (v_t1) begin
               grant     = 1'b1;
               grant_src = SRC_T1;
            end else if (v_t2) begin
               grant     = 1'b1;
               grant_src = SRC_T2;
            end else if (tmr_done) begin
               state_n  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_L;
            end
            if (grant && o_src == SRC_MISS) drop_n = 1'b1;
         end
         ST_GAP: begin
            if (tmr_done) begin
               if (pick != SRC_NONE) begin
                  grant     = 1'b1;
                  grant_src = pick;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (grant) begin
         state_n  = ST_EVT;
         tmr_load = 1'b1;
         tmr_val  = (grant_src == SRC_MISS) ? DUR_MISS_L : DUR_HIT_L;
         case (grant_src)
            SRC_T1: begin
               pend_t1_n   = 1'b0;
               grant_pitch = eff_t1;
            end
            SRC_T2: begin
               pend_t2_n   = 1'b0;
               grant_pitch = eff_t2;
            end
            default: begin
               pend_miss_n = 1'b0;
               grant_pitch = eff_miss;
            end
         endcase
         // A hit supersedes any waiting miss buzz.
         if (grant_src != SRC_MISS) begin
            if (pend_miss_n) drop_n = 1'b1;
            pend_miss_n = 1'b0;
         end
      end

      play_n  = 1'b0;
      src_n   = SRC_NONE;
      limit_n = o_cnt_limit;
      case (state_n)
         ST_EVT: begin
            play_n  = 1'b1;
            src_n   = grant ? grant_src : o_src;
            limit_n = grant_pitch;
         end
         ST_IDLE: begin
`ifdef PIEZO_ARBITER_BGM_EN
            if (i_bgm_en && i_bgm_pitch != '0) begin
               play_n  = 1'b1;
               limit_n = i_bgm_pitch;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pend_t1     <= 1'b0;
         pend_t2     <= 1'b0;
         pend_miss   <= 1'b0;
         o_play_en   <= 1'b0;
         o_cnt_limit <= '0;
         o_src       <= SRC_NONE;
         o_drop      <= 1'b0;
      end else begin
         state       <= state_n;
         pend_t1     <= pend_t1_n;
         pend_t2     <= pend_t2_n;
         pend_miss   <= pend_miss_n;
         o_play_en   <= play_n;
         o_cnt_limit <= limit_n;
         o_src       <= src_n;
         o_drop      <= drop_n;
      end
   end

   // Pitch storage is qualified by the pending bits, so it needs no reset.
   always_ff @(posedge clk) begin
      if (v_t1)   pit_t1   <= i_pitch_t1;
      if (v_t2)   pit_t2   <= i_pitch_t2;
      if (v_miss) pit_miss <= i_pitch_miss;
   end

endmodule

// File: tb/tb_piezo_arbiter.sv
// Directed bench for piezo_arbiter; BGM scenarios follow PIEZO_ARBITER_BGM_EN.
module tb_piezo_arbiter;

   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_tick;
   logic          i_req_t1, i_req_t2, i_req_miss;
   logic [PW-1:0] i_pitch_t1, i_pitch_t2, i_pitch_miss;
   logic          i_bgm_en;
   logic [PW-1:0] i_bgm_pitch;
   logic          o_play_en;
   logic [PW-1:0] o_cnt_limit;
   logic [1:0]    o_src;
   logic          o_drop;

   int checks   = 0;
   int failures = 0;
   int drop_seen = 0;

   piezo_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (i_tick),
      .i_req_t1     (i_req_t1),
      .i_pitch_t1   (i_pitch_t1),
      .i_req_t2     (i_req_t2),
      .i_pitch_t2   (i_pitch_t2),
      .i_req_miss   (i_req_miss),
      .i_pitch_miss (i_pitch_miss),
      .i_bgm_en     (i_bgm_en),
      .i_bgm_pitch  (i_bgm_pitch),
      .o_play_en    (o_play_en),
      .o_cnt_limit  (o_cnt_limit),
      .o_src        (o_src),
      .o_drop       (o_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (o_drop) drop_seen++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic t1, input int p1, input logic t2, input int p2,
                      input logic m, input int pm, input logic tk);
      i_req_t1 = t1; i_pitch_t1 = p1;
      i_req_t2 = t2; i_pitch_t2 = p2;
      i_req_miss = m; i_pitch_miss = pm;
      i_tick = tk;
      step();
      i_req_t1 = 1'b0; i_req_t2 = 1'b0; i_req_miss = 1'b0; i_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         i_tick = 1'b1;
         step();
         i_tick = 1'b0;
      end
   endtask

   task automatic out3(input string tag, input logic pe, input int lim, input logic [1:0] src);
      chk({tag, "_play"}, 64'(o_play_en), 64'(pe));
      chk({tag, "_lim"},  64'(o_cnt_limit), 64'(lim));
      chk({tag, "_src"},  64'(o_src), 64'(src));
   endtask

   int d0;

   initial begin
      rst = 1'b1; i_tick = 1'b0;
      i_req_t1 = 1'b0; i_req_t2 = 1'b0; i_req_miss = 1'b0;
      i_pitch_t1 = '0; i_pitch_t2 = '0; i_pitch_miss = '0;
      i_bgm_en = 1'b0; i_bgm_pitch = '0;
      step(); step();
      out3("reset", 1'b0, 0, 2'b00);
      chk("reset_drop", 64'(o_drop), 64'd0);
      rst = 1'b0;
      step();

      // Single T1 hit: 100 ticks of sound, 5 silent ticks, then idle.
      req(1, 5000, 0, 0, 0, 0, 0);
      out3("t1_grant", 1'b1, 5000, 2'b01);
      ticks(99);
      chk("t1_tick99", 64'(o_play_en), 64'd1);
      ticks(1);
      out3("t1_gap", 1'b0, 5000, 2'b00);
      ticks(5);
      step(); step();
      chk("t1_idle", 64'(o_play_en), 64'd0);

      // Simultaneous T1/T2: T1 first, T2 after the gap, no drop.
      d0 = drop_seen;
      req(1, 4000, 1, 6000, 0, 0, 0);
      out3("both_t1", 1'b1, 4000, 2'b01);
      ticks(100);
      chk("both_gap", 64'(o_play_en), 64'd0);
      ticks(4);
      chk("both_gap4", 64'(o_play_en), 64'd0);
      ticks(1);
      out3("both_t2", 1'b1, 6000, 2'b10);
      ticks(100);
      chk("both_t2_end", 64'(o_play_en), 64'd0);
      ticks(5);
      chk("both_nodrop", 64'(drop_seen - d0), 64'd0);

      // Miss preempted by a fresh T2.
      req(0, 0, 0, 0, 1, 800, 0);
      out3("miss_grant", 1'b1, 800, 2'b11);
      ticks(20);
      req(0, 0, 1, 6000, 0, 0, 0);
      out3("miss_pre", 1'b1, 6000, 2'b10);
      chk("miss_pre_drop", 64'(o_drop), 64'd1);
      step();
      chk("miss_pre_drop_end", 64'(o_drop), 64'd0);
      ticks(105);

      // Miss queued behind T1 plays after the gap for 60 ticks.
      req(1, 5000, 0, 0, 0, 0, 0);
      ticks(10);
      req(0, 0, 0, 0, 1, 800, 0);
      out3("mq_hold", 1'b1, 5000, 2'b01);
      ticks(90);
      ticks(5);
      out3("mq_play", 1'b1, 800, 2'b11);
      ticks(59);
      chk("mq_tick59", 64'(o_play_en), 64'd1);
      ticks(1);
      chk("mq_end", 64'(o_play_en), 64'd0);
      ticks(5);

      // Miss queued, T2 arrives during the gap: T2 wins, miss dropped.
      req(1, 5000, 0, 0, 0, 0, 0);
      ticks(10);
      req(0, 0, 0, 0, 1, 800, 0);
      ticks(92);
      req(0, 0, 1, 6000, 0, 0, 0);
      out3("gapreq_wait", 1'b0, 5000, 2'b00);
      ticks(3);
      out3("gapreq_t2", 1'b1, 6000, 2'b10);
      chk("gapreq_drop", 64'(o_drop), 64'd1);
      step();
      chk("gapreq_drop_end", 64'(o_drop), 64'd0);
      ticks(105);

      // Zero pitch is discarded.
      req(1, 0, 0, 0, 0, 0, 0);
      chk("zero_drop", 64'(o_drop), 64'd1);
      chk("zero_play", 64'(o_play_en), 64'd0);
      step();
      chk("zero_drop_end", 64'(o_drop), 64'd0);
      chk("zero_idle", 64'(o_play_en), 64'd0);

      // Tick in the grant cycle does not count.
      req(1, 5000, 0, 0, 0, 0, 1);
      ticks(99);
      chk("gtick_99", 64'(o_play_en), 64'd1);
      ticks(1);
      chk("gtick_100", 64'(o_play_en), 64'd0);
      ticks(5);

      // Final tick coincides with a fresh T2: preemption reload wins.
      req(1, 5000, 0, 0, 0, 0, 0);
      ticks(99);
      req(0, 0, 1, 7000, 0, 0, 1);
      out3("tpre", 1'b1, 7000, 2'b10);
      ticks(99);
      chk("tpre_99", 64'(o_play_en), 64'd1);
      ticks(1);
      chk("tpre_end", 64'(o_play_en), 64'd0);
      ticks(5);

      // Reset mid-sound clears outputs and the pending T2.
      req(1, 5000, 1, 6000, 0, 0, 0);
      ticks(5);
      rst = 1'b1;
      step();
      out3("rst_mid", 1'b0, 0, 2'b00);
      rst = 1'b0;
      ticks(120);
      chk("rst_lost", 64'(o_play_en), 64'd0);

`ifdef PIEZO_ARBITER_BGM_EN
      i_bgm_en = 1'b1; i_bgm_pitch = 3000;
      step();
      out3("bgm_idle", 1'b1, 3000, 2'b00);
      req(1, 5000, 0, 0, 0, 0, 0);
      out3("bgm_hit", 1'b1, 5000, 2'b01);
      ticks(100);
      out3("bgm_gap", 1'b0, 5000, 2'b00);
      ticks(4);
      chk("bgm_gap4", 64'(o_play_en), 64'd0);
      ticks(1);
      out3("bgm_back", 1'b1, 3000, 2'b00);
      req(1, 5000, 0, 0, 0, 0, 0);
      ticks(3);
      rst = 1'b1;
      step();
      out3("bgm_rst", 1'b0, 0, 2'b00);
      rst = 1'b0;
`else
      i_bgm_en = 1'b1; i_bgm_pitch = 3000;
      step(); step();
      out3("bgm_ignored", 1'b0, 0, 2'b00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
